alu: RTL and testbench

- 32-bit ARM-style integer ALU for the single-cycle datapath.
- Computes ADD, SUB, AND and ORR of two operands, plus the NZCV condition flags, combinationally.
- Provides an optional registered flag copy so conditional-execution logic can sample flags written by an earlier instruction.
- Sits between the register-file/immediate mux (src_a, src_b) and the memory-address/result path.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_adder.sv | 26 ++
 rtl/alu.sv | 66 ++++++
 tb/tb_alu.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation encodings and NZCV flag bit positions
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/alu_adder.sv
// rtl/alu_adder.sv - shared add/subtract adder with invert-B, carry-out and signed overflow
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert_b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff    = invert_b ? ~b : b;
    full     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    sum      = full[WIDTH-1:0];
    cout     = full[WIDTH];
    // Signed overflow: operands agree in sign but the result does not.
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ADD/SUB/AND/ORR ALU with combinational NZCV flags and a registered flag copy
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       alu_control,
  input  logic [1:0]       flag_we,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_flags,
  output logic [3:0]       flags_q
);

  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  assign is_sub   = (alu_control == ALU_SUB);
  assign is_arith = (alu_control == ALU_ADD) || (alu_control == ALU_SUB);

  // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (src_a),
    .b        (src_b),
    .invert_b (is_sub),
    .cin      (is_sub),
    .sum      (sum),
    .cout     (cout),
    .overflow (ovf)
  );

  always_comb begin
    alu_result = sum;
    case (alu_control)
      ALU_ADD: alu_result = sum;
      ALU_SUB: alu_result = sum;
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      default: alu_result = sum;
    endcase
  end

  always_comb begin
    alu_flags         = 4'b0000;
    alu_flags[FLAG_N] = alu_result[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_result == '0);
    alu_flags[FLAG_C] = is_arith & cout;
    alu_flags[FLAG_V] = is_arith & ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (flag_we[1]) flags_q[3:2] <= alu_flags[3:2];
      if (flag_we[0]) flags_q[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu using directed hand-computed vectors
module tb_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [1:0]       alu_control;
  logic [1:0]       flag_we;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [3:0]       flags_q;
  logic             vld;

  int checks;
  int errors;

  typedef struct {
    logic             rst;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       we;
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;
    logic [3:0]       q;
  } vec_t;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;
    logic [3:0]       q;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  alu #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .flag_we     (flag_we),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .flags_q     (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // q is the registered flag value seen during the vector's cycle, i.e. after all earlier edges.
  initial begin
    vecs[0] = '{1'b0, 2'b00, 32'h0000_0005, 32'h0000_0003, 2'b00, 32'h0000_0008, 4'b0000, 4'b0000};
    vecs[1] = '{1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'b0110, 4'b0000};
    vecs[2] = '{1'b0, 2'b01, 32'h0000_0005, 32'h0000_0005, 2'b11, 32'h0000_0000, 4'b0110, 4'b0000};
    vecs[3] = '{1'b0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 32'h8000_0000, 4'b1001, 4'b0110};
    vecs[4] = '{1'b0, 2'b01, 32'h0000_0003, 32'h0000_0005, 2'b00, 32'hFFFF_FFFE, 4'b1000, 4'b1010};
    vecs[5] = '{1'b0, 2'b01, 32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'b0011, 4'b1010};
    vecs[6] = '{1'b0, 2'b10, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b00, 32'h0000_0000, 4'b0100, 4'b1011};
    vecs[7] = '{1'b0, 2'b11, 32'hF000_0000, 32'h0000_000F, 2'b00, 32'hF000_000F, 4'b1000, 4'b1011};
    vecs[8] = '{1'b1, 2'b01, 32'h0000_0005, 32'h0000_0005, 2'b11, 32'h0000_0000, 4'b0110, 4'b1011};
    vecs[9] = '{1'b0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1001, 4'b0000};
  end

  always @(negedge clk) begin
    if (vld) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: output presented with no expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (alu_result !== e.res) begin
          errors++;
          $display("FAIL result[%0d]: got %h expected %h", e.idx, alu_result, e.res);
        end
        checks++;
        if (alu_flags !== e.flg) begin
          errors++;
          $display("FAIL flags[%0d]: got %b expected %b", e.idx, alu_flags, e.flg);
        end
        checks++;
        if (flags_q !== e.q) begin
          errors++;
          $display("FAIL flags_q[%0d]: got %b expected %b", e.idx, flags_q, e.q);
        end
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    vld         = 1'b0;
    reset       = 1'b1;
    src_a       = '0;
    src_b       = '0;
    alu_control = 2'b00;
    flag_we     = 2'b00;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      reset       = vecs[i].rst;
      alu_control = vecs[i].op;
      src_a       = vecs[i].a;
      src_b       = vecs[i].b;
      flag_we     = vecs[i].we;
      sb.push_back('{i, vecs[i].res, vecs[i].flg, vecs[i].q});
      vld         = 1'b1;
    end
    @(posedge clk);
    #1;
    vld     = 1'b0;
    flag_we = 2'b00;
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
